// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MD operation codes, default latencies and decode helper for e_mdu
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_t;

    localparam int MDU_MULT_CYCLES_D = 5;
    localparam int MDU_DIV_CYCLES_D  = 10;

    // Shared with the D-stage stall logic: true for every code that occupies the MDU.
    function automatic logic is_md_instr(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd10);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit owning HI/LO; MADD-class gated by MDU_MADD_EN
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_D,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_L = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_L  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic          we_q, we_d;
    logic [31:0]   hi_d, lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        rs_mag, rt_mag, sq_mag, sr_mag;
    logic [31:0]        quot_s, rem_s, quot_u, rem_u;
    logic               div_zero;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide via magnitudes: 0x80000000/-1 falls out as lo=0x80000000, hi=0.
    assign div_zero = (rt_val == 32'd0);
    assign rs_mag   = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign rt_mag   = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign sq_mag   = div_zero ? 32'd0 : rs_mag / rt_mag;
    assign sr_mag   = div_zero ? 32'd0 : rs_mag % rt_mag;
    assign quot_s   = (rs_val[31] ^ rt_val[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign rem_s    = rs_val[31] ? (~sr_mag + 32'd1) : sr_mag;
    assign quot_u   = div_zero ? 32'd0 : rs_val / rt_val;
    assign rem_u    = div_zero ? 32'd0 : rs_val % rt_val;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        we_d    = we_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT: begin
                            state_d = RUN; cnt_d = MULT_L; we_d = 1'b1;
                            res_d = prod_s;
                        end
                        MD_MULTU: begin
                            state_d = RUN; cnt_d = MULT_L; we_d = 1'b1;
                            res_d = prod_u;
                        end
                        MD_DIV: begin
                            state_d = RUN; cnt_d = DIV_L; we_d = !div_zero;
                            res_d = {rem_s, quot_s};
                        end
                        MD_DIVU: begin
                            state_d = RUN; cnt_d = DIV_L; we_d = !div_zero;
                            res_d = {rem_u, quot_u};
                        end
`ifdef MDU_MADD_EN
                        MD_MADD: begin
                            state_d = RUN; cnt_d = MULT_L; we_d = 1'b1;
                            res_d = {hi, lo} + prod_s;
                        end
                        MD_MADDU: begin
                            state_d = RUN; cnt_d = MULT_L; we_d = 1'b1;
                            res_d = {hi, lo} + prod_u;
                        end
                        MD_MSUB: begin
                            state_d = RUN; cnt_d = MULT_L; we_d = 1'b1;
                            res_d = {hi, lo} - prod_s;
                        end
                        MD_MSUBU: begin
                            state_d = RUN; cnt_d = MULT_L; we_d = 1'b1;
                            res_d = {hi, lo} - prod_u;
                        end
`endif
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    if (we_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            we_q    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            we_q    <= we_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

    assign busy = (state_q == RUN);

    // The D stage is expected to hold MD instructions back while the unit is occupied.
    assert property (@(posedge clk) disable iff (reset) !(start && busy && is_md_instr(md_op)))
        else $warning("e_mdu: MD start while busy was dropped");

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - randomized self-checking bench for e_mdu against an arithmetic reference model
module tb_e_mdu;

    localparam int MULT_L = 5;
    localparam int DIV_L  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    e_mdu #(.MULT_CYCLES(MULT_L), .DIV_CYCLES(DIV_L)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: updates hi_m/lo_m to the value expected once the op retires.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        acc = {hi_m, lo_m};
        lat = 0;
        case (op)
            4'd1: begin p = sa * sb; {hi_m, lo_m} = p; lat = MULT_L; end
            4'd2: begin p = ua * ub; {hi_m, lo_m} = p; lat = MULT_L; end
            4'd3: begin
                lat = DIV_L;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    lo_m = q[31:0]; hi_m = r[31:0];
                end
            end
            4'd4: begin
                lat = DIV_L;
                if (b != 0) begin
                    p = ua / ub; lo_m = p[31:0];
                    p = ua % ub; hi_m = p[31:0];
                end
            end
            4'd5: hi_m = a;
            4'd6: lo_m = a;
`ifdef MDU_MADD_EN
            4'd7:  begin p = sa * sb; {hi_m, lo_m} = acc + p; lat = MULT_L; end
            4'd8:  begin p = ua * ub; {hi_m, lo_m} = acc + p; lat = MULT_L; end
            4'd9:  begin p = sa * sb; {hi_m, lo_m} = acc - p; lat = MULT_L; end
            4'd10: begin p = ua * ub; {hi_m, lo_m} = acc - p; lat = MULT_L; end
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [63:0] old;
        old = {hi_m, lo_m};
        model(op, a, b, lat);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        for (int i = 0; i < lat; i++) begin
            check($sformatf("busy_op%0d_c%0d", op, i + 1), {63'd0, busy}, 64'd1);
            if (i == 0) check($sformatf("hold_op%0d", op), {hi, lo}, old);
            @(posedge clk); #1;
        end
        check($sformatf("idle_op%0d", op), {63'd0, busy}, 64'd0);
        check($sformatf("hilo_op%0d", op), {hi, lo}, {hi_m, lo_m});
    endtask

    initial begin
        int busy_cnt;
        logic [31:0] a, b;
        logic [3:0] op;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk) reset = 1'b0;

        run_op(4'd1, 32'hFFFFFFFF, 32'd2);
        run_op(4'd2, 32'hFFFFFFFF, 32'd2);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2);
        run_op(4'd4, 32'd7, 32'd0);
        run_op(4'd5, 32'h12345678, 32'd0);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        run_op(4'd3, 32'd9, 32'hFFFFFFFE);
        run_op(4'd0, 32'h1, 32'h1);
        run_op(4'd13, 32'h1, 32'h1);

        run_op(4'd5, 32'd0, 32'd0);
        run_op(4'd6, 32'hFFFFFFFF, 32'd0);
        run_op(4'd8, 32'd1, 32'd1);
        run_op(4'd9, 32'd3, 32'hFFFFFFFE);

        for (int t = 0; t < 40; t++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            run_op(op, a, b);
        end

        // A MULT pulsed mid-DIV must be ignored without stretching the busy window.
        model(4'd3, 32'd100, 32'd7, busy_cnt);
        @(negedge clk);
        start = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        busy_cnt = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            if (i == 2) begin
                @(negedge clk);
                start = 1'b1; md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd5;
                @(posedge clk); #1;
                start = 1'b0; md_op = 4'd0;
            end else begin
                @(posedge clk); #1;
            end
            busy_cnt++;
        end
        check("ignored_busy_len", 64'(busy_cnt), 64'(DIV_L));
        check("ignored_hilo", {hi, lo}, {hi_m, lo_m});

        // Reset three cycles into a DIV clears everything at once and suppresses the write.
        run_op(4'd5, 32'hDEAD0001, 32'd0);
        @(negedge clk);
        start = 1'b1; md_op = 4'd3; rs_val = 32'd50; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        hi_m = 32'd0; lo_m = 32'd0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk) reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_late_busy", {63'd0, busy}, 64'd0);
        check("abort_late_hilo", {hi, lo}, 64'd0);

        run_op(4'd2, 32'h0000FFFF, 32'h00010001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
